// File: rtl/load_writeback.sv
// Load-completion unit: accepts one load at a time, reads the aligned word and
// writes the extracted or merged value to the GRF in a single WRITE cycle.
module load_writeback #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_pc,
    input  logic [31:0] req_addr,
    input  logic [4:0]  req_rt,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_old,
    output logic        dm_re,
    output logic [31:0] dm_addr,
    input  logic [31:0] dm_rdata,
    input  logic        dm_rvalid,
    output logic        RegWrite,
    output logic [4:0]  A3,
    output logic [31:0] WD,
    output logic [31:0] PC,
    output logic        err_align,
    output logic        err_timeout
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, ERR} state_t;

    localparam logic [2:0] T_LW  = 3'd0;
    localparam logic [2:0] T_LB  = 3'd1;
    localparam logic [2:0] T_LBU = 3'd2;
    localparam logic [2:0] T_LH  = 3'd3;
    localparam logic [2:0] T_LHU = 3'd4;
    localparam logic [2:0] T_LWL = 3'd5;
    localparam logic [2:0] T_LWR = 3'd6;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [31:0] pc_r;
    logic [31:0] addr_r;
    logic [31:0] old_r;
    logic [4:0]  rt_r;
    logic [2:0]  type_r;
    logic        accept;
    logic        misaligned;

    function automatic logic [31:0] load_result(input logic [2:0]  t,
                                                input logic [1:0]  k,
                                                input logic [31:0] mem,
                                                input logic [31:0] old);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] bs;
        logic signed [31:0] hs;
        logic [5:0]         sh;
        b  = mem[{k, 3'b000} +: 8];
        h  = mem[{k[1], 4'b0000} +: 16];
        bs = 32'(b);
        hs = 32'(h);
        sh = {1'b0, k, 3'b000};
        case (t)
            T_LB:    load_result = bs;
            T_LBU:   load_result = {24'd0, b};
            T_LH:    load_result = hs;
            T_LHU:   load_result = {16'd0, h};
            // lwl/lwr keep the bytes of old that the unaligned word does not cover
            T_LWL:   load_result = (mem << (6'd24 - sh)) | (old & (32'hFFFF_FFFF >> (sh + 6'd8)));
            T_LWR:   load_result = (mem >> sh) | (old & ~(32'hFFFF_FFFF >> sh));
            default: load_result = mem;
        endcase
    endfunction

    always_comb begin
        misaligned = 1'b0;
        case (req_type)
            T_LH, T_LHU:                misaligned = req_addr[0];
            T_LB, T_LBU, T_LWL, T_LWR:  misaligned = 1'b0;
            T_LW:                       misaligned = |req_addr[1:0];
            default:                    misaligned = |req_addr[1:0];
        endcase
    end

    assign accept      = (state == IDLE) && req_valid;
    assign req_ready   = (state == IDLE) && reset;
    assign dm_re       = (state == READ);
    assign dm_addr     = {addr_r[31:2], 2'b00};
    assign err_align   = (state == ERR);
    assign err_timeout = (state == READ) && (cnt == CNT_LAST) && !dm_rvalid;
    assign RegWrite    = (state == WRITE) && (A3 != 5'd0);

    // request capture: plain data, only meaningful after an accept
    always_ff @(posedge clk) begin
        if (accept) begin
            pc_r   <= req_pc;
            addr_r <= req_addr;
            rt_r   <= req_rt;
            type_r <= req_type;
            old_r  <= req_old;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
            A3    <= 5'd0;
            WD    <= 32'd0;
            PC    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= 8'd0;
                    if (req_valid) state <= misaligned ? ERR : READ;
                end
                READ: begin
                    // data beats the timeout when both land on the last wait cycle
                    if (dm_rvalid) begin
                        WD    <= load_result(type_r, addr_r[1:0], dm_rdata, old_r);
                        A3    <= rt_r;
                        PC    <= pc_r;
                        state <= WRITE;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WRITE:   state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_writeback.sv
// Directed bench for load_writeback, built with TIMEOUT=4.
module tb_load_writeback;
    localparam logic [2:0] T_LW = 3'd0, T_LB = 3'd1, T_LBU = 3'd2, T_LH = 3'd3;
    localparam logic [2:0] T_LHU = 3'd4, T_LWL = 3'd5, T_LWR = 3'd6, T_ALT = 3'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic [31:0] req_addr;
    logic [4:0]  req_rt;
    logic [2:0]  req_type;
    logic [31:0] req_old;
    logic        dm_re;
    logic [31:0] dm_addr;
    logic [31:0] dm_rdata;
    logic        dm_rvalid;
    logic        RegWrite;
    logic [4:0]  A3;
    logic [31:0] WD;
    logic [31:0] PC;
    logic        err_align;
    logic        err_timeout;

    int pass = 0;
    int total = 0;
    logic [31:0] cur_pc = 32'h0040_3000;
    int obs_re, obs_nrw, obs_rw, obs_al, obs_to, obs_rdy;
    logic [31:0] obs_wd, obs_pc, obs_daddr;
    logic [4:0]  obs_a3;

    load_writeback #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_pc(req_pc), .req_addr(req_addr), .req_rt(req_rt), .req_type(req_type),
        .req_old(req_old), .dm_re(dm_re), .dm_addr(dm_addr), .dm_rdata(dm_rdata),
        .dm_rvalid(dm_rvalid), .RegWrite(RegWrite), .A3(A3), .WD(WD), .PC(PC),
        .err_align(err_align), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Issues one load, returns rvalid in cycle N+1+d (d<0: never) and records
    // per-cycle observations, counted from the accept edge N.
    task automatic run_load(input logic [2:0] t, input logic [31:0] addr, input logic [4:0] rt,
                            input logic [31:0] old, input logic [31:0] rd, input int d);
        cur_pc = cur_pc + 32'd4;
        req_valid = 1'b1; req_pc = cur_pc; req_addr = addr; req_rt = rt; req_type = t; req_old = old;
        obs_re = 0; obs_nrw = 0; obs_rw = -1; obs_al = -1; obs_to = -1; obs_rdy = -1;
        obs_wd = 'x; obs_a3 = 'x; obs_pc = 'x; obs_daddr = 'x;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_rt = 5'd31; req_old = 32'd0; req_type = T_LW;
        for (int c = 1; c <= 40 && obs_rdy < 0; c++) begin
            dm_rvalid = (c == d + 1);
            dm_rdata  = (c == d + 1) ? rd : 32'hDEAD_BEEF;
            #1;
            if (dm_re) begin obs_re++; obs_daddr = dm_addr; end
            if (RegWrite) begin obs_nrw++; obs_rw = c; obs_wd = WD; obs_a3 = A3; obs_pc = PC; end
            if (err_align) obs_al = c;
            if (err_timeout) obs_to = c;
            if (req_ready) obs_rdy = c;
            else begin @(posedge clk); #1; end
        end
        dm_rvalid = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        total++; if (req_ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", req_ready); else pass++;
        total++; if (dm_re !== 1'b0) $display("FAIL rst_dm_re got %b exp 0", dm_re); else pass++;
        total++; if (RegWrite !== 1'b0) $display("FAIL rst_regwrite got %b exp 0", RegWrite); else pass++;
        total++; if ({A3, WD, PC} !== 69'd0) $display("FAIL rst_outs got %h/%h/%h exp 0", A3, WD, PC); else pass++;
        total++; if ({err_align, err_timeout} !== 2'b00) $display("FAIL rst_err got %b exp 00", {err_align, err_timeout}); else pass++;
        @(posedge clk); #1; reset = 1'b1; #1;
        total++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready got %b exp 1", req_ready); else pass++;
    endtask

    task automatic test_extract;
        run_load(T_LB, 32'h1002, 5'd5, 32'd0, 32'h12F4_5678, 0);
        total++; if (obs_rw !== 2) $display("FAIL lb_rw_cycle got %0d exp 2", obs_rw); else pass++;
        total++; if (obs_nrw !== 1) $display("FAIL lb_rw_count got %0d exp 1", obs_nrw); else pass++;
        total++; if (obs_a3 !== 5'd5) $display("FAIL lb_a3 got %0d exp 5", obs_a3); else pass++;
        total++; if (obs_wd !== 32'hFFFF_FFF4) $display("FAIL lb_wd got %h exp fffffff4", obs_wd); else pass++;
        total++; if (obs_pc !== cur_pc) $display("FAIL lb_pc got %h exp %h", obs_pc, cur_pc); else pass++;
        total++; if (obs_daddr !== 32'h1000) $display("FAIL lb_dm_addr got %h exp 00001000", obs_daddr); else pass++;
        total++; if (obs_rdy !== 3) $display("FAIL lb_ready_cycle got %0d exp 3", obs_rdy); else pass++;
        run_load(T_LBU, 32'h1002, 5'd5, 32'd0, 32'h12F4_5678, 0);
        total++; if (obs_wd !== 32'h0000_00F4) $display("FAIL lbu_wd got %h exp 000000f4", obs_wd); else pass++;
        run_load(T_LH, 32'h1002, 5'd6, 32'd0, 32'h8001_5678, 0);
        total++; if (obs_wd !== 32'hFFFF_8001) $display("FAIL lh_wd got %h exp ffff8001", obs_wd); else pass++;
        run_load(T_LHU, 32'h1002, 5'd6, 32'd0, 32'h8001_5678, 0);
        total++; if (obs_wd !== 32'h0000_8001) $display("FAIL lhu_wd got %h exp 00008001", obs_wd); else pass++;
        run_load(T_LW, 32'h1000, 5'd7, 32'd0, 32'hCAFE_BABE, 2);
        total++; if (obs_wd !== 32'hCAFE_BABE) $display("FAIL lw_wd got %h exp cafebabe", obs_wd); else pass++;
        total++; if (obs_rw !== 4 || obs_rdy !== 5) $display("FAIL lw_d2_timing got rw=%0d rdy=%0d exp rw=4 rdy=5", obs_rw, obs_rdy); else pass++;
        total++; if (obs_re !== 3) $display("FAIL lw_d2_re_cycles got %0d exp 3", obs_re); else pass++;
        run_load(T_ALT, 32'h1004, 5'd8, 32'd0, 32'h0123_4567, 0);
        total++; if (obs_wd !== 32'h0123_4567) $display("FAIL type7_wd got %h exp 01234567", obs_wd); else pass++;
    endtask

    task automatic test_merge;
        run_load(T_LWL, 32'h2001, 5'd12, 32'h1122_3344, 32'hAABB_CCDD, 0);
        total++; if (obs_wd !== 32'hCCDD_3344) $display("FAIL lwl_k1 got %h exp ccdd3344", obs_wd); else pass++;
        run_load(T_LWR, 32'h2001, 5'd12, 32'h1122_3344, 32'hAABB_CCDD, 0);
        total++; if (obs_wd !== 32'h11AA_BBCC) $display("FAIL lwr_k1 got %h exp 11aabbcc", obs_wd); else pass++;
        run_load(T_LWL, 32'h2003, 5'd12, 32'h1122_3344, 32'hAABB_CCDD, 0);
        total++; if (obs_wd !== 32'hAABB_CCDD) $display("FAIL lwl_k3 got %h exp aabbccdd", obs_wd); else pass++;
        run_load(T_LWL, 32'h2000, 5'd12, 32'h1122_3344, 32'hAABB_CCDD, 0);
        total++; if (obs_wd !== 32'hDD22_3344) $display("FAIL lwl_k0 got %h exp dd223344", obs_wd); else pass++;
        run_load(T_LWR, 32'h2003, 5'd12, 32'h1122_3344, 32'hAABB_CCDD, 0);
        total++; if (obs_wd !== 32'h1122_33AA) $display("FAIL lwr_k3 got %h exp 112233aa", obs_wd); else pass++;
        run_load(T_LWR, 32'h2000, 5'd12, 32'h1122_3344, 32'hAABB_CCDD, 0);
        total++; if (obs_wd !== 32'hAABB_CCDD) $display("FAIL lwr_k0 got %h exp aabbccdd", obs_wd); else pass++;
    endtask

    task automatic test_misaligned;
        run_load(T_LW, 32'h1001, 5'd3, 32'd0, 32'h5555_5555, 0);
        total++; if (obs_al !== 1) $display("FAIL lw_mis_align_cycle got %0d exp 1", obs_al); else pass++;
        total++; if (obs_re !== 0 || obs_nrw !== 0) $display("FAIL lw_mis_side got re=%0d rw=%0d exp 0/0", obs_re, obs_nrw); else pass++;
        total++; if (obs_rdy !== 2) $display("FAIL lw_mis_ready got %0d exp 2", obs_rdy); else pass++;
        run_load(T_LH, 32'h1003, 5'd3, 32'd0, 32'h5555_5555, 0);
        total++; if (obs_al !== 1 || obs_rdy !== 2 || obs_re !== 0 || obs_nrw !== 0)
            $display("FAIL lh_mis got al=%0d rdy=%0d re=%0d rw=%0d exp 1/2/0/0", obs_al, obs_rdy, obs_re, obs_nrw); else pass++;
        run_load(T_LHU, 32'h1001, 5'd3, 32'd0, 32'h5555_5555, 0);
        total++; if (obs_al !== 1 || obs_nrw !== 0) $display("FAIL lhu_mis got al=%0d rw=%0d exp 1/0", obs_al, obs_nrw); else pass++;
        run_load(T_ALT, 32'h1002, 5'd3, 32'd0, 32'h5555_5555, 0);
        total++; if (obs_al !== 1 || obs_nrw !== 0) $display("FAIL type7_mis got al=%0d rw=%0d exp 1/0", obs_al, obs_nrw); else pass++;
        run_load(T_LB, 32'h1003, 5'd3, 32'd0, 32'h12F4_5678, 0);
        total++; if (obs_al !== -1 || obs_wd !== 32'h0000_0012) $display("FAIL lb_k3 got al=%0d wd=%h exp -1/00000012", obs_al, obs_wd); else pass++;
    endtask

    task automatic test_timeout;
        run_load(T_LW, 32'h3000, 5'd4, 32'd0, 32'h0, -1);
        total++; if (obs_to !== 4) $display("FAIL to_cycle got %0d exp 4", obs_to); else pass++;
        total++; if (obs_rdy !== 5) $display("FAIL to_ready got %0d exp 5", obs_rdy); else pass++;
        total++; if (obs_nrw !== 0 || obs_re !== 4) $display("FAIL to_side got rw=%0d re=%0d exp 0/4", obs_nrw, obs_re); else pass++;
        run_load(T_LW, 32'h3000, 5'd4, 32'd0, 32'h7777_1234, 3);
        total++; if (obs_to !== -1) $display("FAIL tie_timeout got %0d exp -1", obs_to); else pass++;
        total++; if (obs_rw !== 5 || obs_wd !== 32'h7777_1234) $display("FAIL tie_write got rw=%0d wd=%h exp 5/77771234", obs_rw, obs_wd); else pass++;
    endtask

    task automatic test_back_to_back;
        int n_re, n_rw, acc;
        logic [31:0] first_pc;
        cur_pc = cur_pc + 32'd4; first_pc = cur_pc;
        req_valid = 1'b1; req_type = T_LW; req_addr = 32'h2000; req_rt = 5'd0; req_old = 32'd0; req_pc = cur_pc;
        @(posedge clk); #1;
        req_addr = 32'h2010; req_rt = 5'd7; req_pc = first_pc + 32'd4;
        n_re = 0; n_rw = 0; acc = -1;
        for (int c = 1; c <= 20 && acc < 0; c++) begin
            dm_rvalid = (c == 3);
            dm_rdata  = (c == 3) ? 32'h9999_0000 : 32'hDEAD_BEEF;
            #1;
            if (dm_re && dm_addr == 32'h2000) n_re++;
            if (RegWrite) n_rw++;
            if (req_ready) acc = c;
            else begin @(posedge clk); #1; end
        end
        dm_rvalid = 1'b0;
        total++; if (n_re !== 3) $display("FAIL rt0_re_cycles got %0d exp 3", n_re); else pass++;
        total++; if (n_rw !== 0) $display("FAIL rt0_regwrite got %0d exp 0", n_rw); else pass++;
        total++; if (acc !== 5) $display("FAIL held_req_ready got %0d exp 5", acc); else pass++;
        @(posedge clk); #1;
        req_valid = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'h1111_2222; #1;
        total++; if (dm_re !== 1'b1 || dm_addr !== 32'h2010) $display("FAIL second_read got re=%b addr=%h exp 1/00002010", dm_re, dm_addr); else pass++;
        @(posedge clk); #1; dm_rvalid = 1'b0; #1;
        total++; if (RegWrite !== 1'b1 || A3 !== 5'd7 || WD !== 32'h1111_2222 || PC !== first_pc + 32'd4)
            $display("FAIL second_write got rw=%b a3=%0d wd=%h pc=%h exp 1/7/11112222/%h", RegWrite, A3, WD, PC, first_pc + 32'd4); else pass++;
        @(posedge clk); #2;
        total++; if (req_ready !== 1'b1) $display("FAIL second_ready got %b exp 1", req_ready); else pass++;
        cur_pc = first_pc + 32'd4;
    endtask

    task automatic test_reset_mid;
        int n;
        cur_pc = cur_pc + 32'd4;
        req_valid = 1'b1; req_type = T_LW; req_addr = 32'h3004; req_rt = 5'd9; req_old = 32'd0; req_pc = cur_pc;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (dm_re !== 1'b1) $display("FAIL mid_in_read got %b exp 1", dm_re); else pass++;
        reset = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'h5555_5555; #1;
        total++; if ({dm_re, RegWrite, req_ready} !== 3'b000) $display("FAIL mid_ctrl got %b exp 000", {dm_re, RegWrite, req_ready}); else pass++;
        total++; if ({A3, WD, PC} !== 69'd0) $display("FAIL mid_outs got %h/%h/%h exp 0", A3, WD, PC); else pass++;
        n = 0;
        repeat (2) begin @(posedge clk); #1; if (RegWrite || err_align || err_timeout) n++; end
        reset = 1'b1;
        repeat (3) begin @(posedge clk); #1; if (RegWrite || err_align || err_timeout) n++; end
        dm_rvalid = 1'b0; #1;
        total++; if (n !== 0) $display("FAIL mid_no_write got %0d exp 0", n); else pass++;
        total++; if (req_ready !== 1'b1) $display("FAIL mid_ready got %b exp 1", req_ready); else pass++;
        run_load(T_LW, 32'h3008, 5'd9, 32'd0, 32'h0BAD_F00D, 1);
        total++; if (obs_rw !== 3 || obs_wd !== 32'h0BAD_F00D || obs_a3 !== 5'd9)
            $display("FAIL post_reset_lw got rw=%0d wd=%h a3=%0d exp 3/0badf00d/9", obs_rw, obs_wd, obs_a3); else pass++;
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_pc = 32'd0; req_addr = 32'd0; req_rt = 5'd0;
        req_type = T_LW; req_old = 32'd0; dm_rdata = 32'd0; dm_rvalid = 1'b0;
        test_reset();
        test_extract();
        test_merge();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/load_writeback.md
# load_writeback

Sequential load-completion unit between the data-memory read port and the GRF write port. It accepts one load request at a time and issues an aligned word read to data memory. It extracts or merges the returned data per load type (lw/lb/lbu/lh/lhu/lwl/lwr) and drives exactly one GRF write (`RegWrite`/`A3`/`WD`/`PC`) per completed load. Misaligned accesses and memory timeouts are flagged and complete without a register write.

## Interface
- `TIMEOUT`, 16: maximum number of READ cycles waited for `dm_rvalid`; range 1..255.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: load request present.
- `req_ready` out 1: unit can accept a request.
- `req_pc` in 32: PC of the load, forwarded to `PC`.
- `req_addr` in 32: byte address.
- `req_rt` in 5: destination register.
- `req_type` in 3: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu, 101 lwl, 110 lwr; 111 is treated as lw.
- `req_old` in 32: current value of `req_rt`, used by the lwl/lwr merge.
- `dm_re` out 1: memory read strobe.
- `dm_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `dm_rdata` in 32: read data.
- `dm_rvalid` in 1: `dm_rdata` is valid this cycle.
- `RegWrite` out 1: GRF write enable.
- `A3` out 5: GRF write register.
- `WD` out 32: GRF write data.
- `PC` out 32: PC forwarded for the write trace.
- `err_align` out 1: one-cycle pulse on a misaligned lw/lh/lhu.
- `err_timeout` out 1: one-cycle pulse on a memory timeout.

## Operation
- The FSM has four states: IDLE, READ, WRITE, ERR.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`, capture pc, addr, rt, type and old into internal registers.
  - Go to ERR if the access is misaligned: lw with `addr[1:0]`≠0, or lh/lhu with `addr[0]`≠0. Otherwise go to READ.
  - Bytes: lb/lbu are never misaligned.
- **READ:**
  - `dm_re`=1 and `dm_addr` is driven from the captured address.
  - An 8-bit wait counter starts at 0 and increments every READ cycle.
  - On `dm_rvalid`, compute the result into a WD register and go to WRITE.
  - If the counter reaches `TIMEOUT`-1 without `dm_rvalid`: pulse `err_timeout` and go to IDLE.
  - If `dm_rvalid` arrives in the same cycle the counter reaches `TIMEOUT`-1, the data wins and no timeout is raised.
- **WRITE:**
  - For exactly one cycle, drive `RegWrite`=(rt≠0), `A3`=rt, `WD`=result, `PC`=pc.
  - Then go to IDLE.
- **ERR:**
  - `err_align`=1 for one cycle, with no memory read and no register write.
  - Then go to IDLE.
- **Result computation.** k=`addr[1:0]`; byte(k)=`dm_rdata[8k+7:8k]`; half=`dm_rdata[16*addr[1]+15 : 16*addr[1]]`.
  - lw: `dm_rdata`.
  - lb / lbu: byte(k), sign- / zero-extended.
  - lh / lhu: half, sign- / zero-extended.
  - lwl: `(dm_rdata << (24-8k)) | (old & (32'hFFFFFFFF >> (8k+8)))`. This gives k=0 → `{mem[7:0],old[23:0]}` and k=3 → `mem`.
  - lwr: `(dm_rdata >> 8k) | (old & ~(32'hFFFFFFFF >> 8k))`. This gives k=0 → `mem` and k=3 → `{old[31:8],mem[31:24]}`.
  - All shifts are 32-bit logical; the masks are computed in 32 bits.
- **rt=0.** The memory read is still performed and WRITE is still entered, but `RegWrite` stays 0.
- **Output defaults.** Outside WRITE: `RegWrite`=0. `A3`, `WD` and `PC` hold their last values, and are 0 after reset.

## Timing
- **Reset (`reset`=0, asynchronous):**
  - State goes to IDLE, the counter to 0, and all output registers to 0.
  - `req_ready`, `dm_re`, `RegWrite`, `err_align` and `err_timeout` are 0.
  - `req_ready` is gated to 0 while `reset`=0.
- **Reset mid-operation** (READ or WRITE): the load is abandoned. No `RegWrite` is issued and no error pulse is raised.
- **Latency.** Request accepted at edge N.
  - `dm_re` is high from cycle N+1.
  - If `dm_rvalid` arrives in cycle N+1+d, `RegWrite` is high in cycle N+2+d and `req_ready` returns in cycle N+3+d.
  - Best-case throughput is one load per 3 cycles.
- **Misaligned access.** `err_align` is high in cycle N+1 and `req_ready` returns in cycle N+2.
- **Timeout.** `err_timeout` is high in the last READ cycle (N+`TIMEOUT`) and `req_ready` returns in cycle N+`TIMEOUT`+1.
- **Handshake:**
  - `req_ready` is a function of state only (IDLE), never of `req_valid`.
  - A request held with `req_valid` while `req_ready`=0 is not consumed.
  - `req_*` inputs are sampled only at the accept edge.
- **Memory side.** `dm_rvalid` outside READ is ignored; `dm_rdata` is sampled only on the accepting READ edge.

## Test plan
- **lb sign-extension.** lb at addr 0x1002, `dm_rdata`=0x12F45678 with rvalid at d=0, rt=5 → `RegWrite` pulse in cycle N+2, `A3`=5, `WD`=0xFFFFFFF4; with lbu the same load gives `WD`=0x000000F4.
- **lwl/lwr merge.** `dm_rdata`=0xAABBCCDD, old=0x11223344:
  - lwl k=1 → `WD`=0xCCDD3344.
  - lwr k=1 → `WD`=0x11AABBCC.
  - lwl k=3 → `WD`=0xAABBCCDD.
- **Misaligned lw.** lw at addr 0x1001 → `err_align` high in cycle N+1, `dm_re` never high, no `RegWrite`, `req_ready` back in cycle N+2; same for lh at addr 0x1003.
- **rt=0 and back-pressure.** lw with rt=0 → `dm_re` asserted, no `RegWrite`. A second request held during READ is not accepted until IDLE, then completes normally.
- **Timeout and tie.** `TIMEOUT`=4 with no rvalid → `err_timeout` high in cycle N+4, no write. With rvalid in exactly that cycle → write occurs and there is no `err_timeout`.
- **Reset mid-operation.** `reset` driven low during READ → outputs 0 immediately and no `RegWrite` follows. After release, a new lw completes with correct `WD`.
